// File: rtl/register_file_2r1w.sv
// Two-read, one-write general-purpose register file with registered read outputs.
// Define REGFILE_BYPASS_EN to forward same-edge write data onto the read ports.
module register_file_2r1w #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ReadEnable,
    input  logic [ADDR_BITS-1:0] ReadAddrA,
    input  logic [ADDR_BITS-1:0] ReadAddrB,
    input  logic                 WriteEnable,
    input  logic [ADDR_BITS-1:0] WriteAddr,
    input  logic [WIDTH-1:0]     WriteData,
    output logic [WIDTH-1:0]     DataA,
    output logic [WIDTH-1:0]     DataB,
    output logic                 ReadValid
);

    localparam int NREGS = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] data_a_q, data_a_d;
    logic [WIDTH-1:0] data_b_q, data_b_d;
    logic             read_valid_q;

    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (ReadEnable) begin
            data_a_d = regs_q[ReadAddrA];
            data_b_d = regs_q[ReadAddrB];
`ifdef REGFILE_BYPASS_EN
            // Forward the value being written this edge instead of the stale entry.
            if (WriteEnable && (ReadAddrA == WriteAddr)) data_a_d = WriteData;
            if (WriteEnable && (ReadAddrB == WriteAddr)) data_b_d = WriteData;
`endif
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            data_a_q     <= '0;
            data_b_q     <= '0;
            read_valid_q <= 1'b0;
        end else begin
            if (WriteEnable) regs_q[WriteAddr] <= WriteData;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            read_valid_q <= ReadEnable;
        end
    end

    assign DataA     = data_a_q;
    assign DataB     = data_b_q;
    assign ReadValid = read_valid_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed self-checking bench for register_file_2r1w (either REGFILE_BYPASS_EN build).
module tb_register_file_2r1w;

    localparam int WIDTH     = 16;
    localparam int ADDR_BITS = 4;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic                 ReadEnable;
    logic [ADDR_BITS-1:0] ReadAddrA;
    logic [ADDR_BITS-1:0] ReadAddrB;
    logic                 WriteEnable;
    logic [ADDR_BITS-1:0] WriteAddr;
    logic [WIDTH-1:0]     WriteData;
    logic [WIDTH-1:0]     DataA;
    logic [WIDTH-1:0]     DataB;
    logic                 ReadValid;

    int checks = 0;
    int errors = 0;

    register_file_2r1w #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ReadEnable (ReadEnable),
        .ReadAddrA  (ReadAddrA),
        .ReadAddrB  (ReadAddrB),
        .WriteEnable(WriteEnable),
        .WriteAddr  (WriteAddr),
        .WriteData  (WriteData),
        .DataA      (DataA),
        .DataB      (DataB),
        .ReadValid  (ReadValid)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic we, input logic [ADDR_BITS-1:0] wa,
                         input logic [WIDTH-1:0] wd, input logic re,
                         input logic [ADDR_BITS-1:0] ra, input logic [ADDR_BITS-1:0] rb);
        Reset       = rst_n;
        WriteEnable = we;
        WriteAddr   = wa;
        WriteData   = wd;
        ReadEnable  = re;
        ReadAddrA   = ra;
        ReadAddrB   = rb;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_same;

        // Reset edge with read/write requests that must be ignored
        drive(1'b0, 1'b1, 4'd3, 16'hDEAD, 1'b1, 4'd3, 4'd3);
        step();
        check("reset_dataA", DataA, 16'h0000);
        check("reset_dataB", DataB, 16'h0000);
        check("reset_valid", {15'd0, ReadValid}, 16'h0000);

        drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd15);
        step();
        check("post_reset_A3", DataA, 16'h0000);
        check("post_reset_B15", DataB, 16'h0000);
        check("post_reset_valid", {15'd0, ReadValid}, 16'h0001);

        // Write then read the same register on both ports
        drive(1'b1, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd0);
        step();
        check("hold_valid_low", {15'd0, ReadValid}, 16'h0000);
        drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 4'd5);
        step();
        check("r5_portA", DataA, 16'hBEEF);
        check("r5_portB", DataB, 16'hBEEF);

        // Same-edge write and read of R7
        drive(1'b1, 1'b1, 4'd7, 16'h00AA, 1'b0, 4'd0, 4'd0);
        step();
        drive(1'b1, 1'b1, 4'd7, 16'h1234, 1'b1, 4'd7, 4'd7);
        step();
`ifdef REGFILE_BYPASS_EN
        exp_same = 16'h1234;
`else
        exp_same = 16'h00AA;
`endif
        check("same_edge_A", DataA, exp_same);
        check("same_edge_B", DataB, exp_same);
        drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd5);
        step();
        check("r7_next_read", DataA, 16'h1234);
        check("r5_still", DataB, 16'hBEEF);

        // Held outputs ignore a write to the register they show
        drive(1'b1, 1'b1, 4'd2, 16'h1111, 1'b0, 4'd0, 4'd0);
        step();
        drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 4'd2);
        step();
        check("r2_first", DataA, 16'h1111);
        drive(1'b1, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd9, 4'd9);
        step();
        check("held_A", DataA, 16'h1111);
        check("held_valid", {15'd0, ReadValid}, 16'h0000);
        drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 4'd2);
        step();
        check("r2_updated", DataA, 16'h2222);
        check("r2_valid", {15'd0, ReadValid}, 16'h0001);

        // Fill every register, then read pairs
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0, 4'd0, 4'd0);
            step();
        end
        drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 4'd15);
        step();
        check("pair0_A", DataA, 16'h1000);
        check("pair15_B", DataB, 16'h100F);
        drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd8, 4'd7);
        step();
        check("pair8_A", DataA, 16'h1008);
        check("pair7_B", DataB, 16'h1007);

        // Back-to-back writes to one address: last wins
        drive(1'b1, 1'b1, 4'd9, 16'hAAAA, 1'b0, 4'd0, 4'd0);
        step();
        drive(1'b1, 1'b1, 4'd9, 16'hBBBB, 1'b0, 4'd0, 4'd0);
        step();
        drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 4'd0);
        step();
        check("waw_r9", DataA, 16'hBBBB);
        check("r0_writable", DataB, 16'h1000);

        // Reset beats an in-flight write and read
        drive(1'b1, 1'b1, 4'd4, 16'hFFFF, 1'b0, 4'd0, 4'd0);
        step();
        drive(1'b0, 1'b1, 4'd4, 16'h5555, 1'b1, 4'd4, 4'd4);
        step();
        check("midreset_A", DataA, 16'h0000);
        check("midreset_valid", {15'd0, ReadValid}, 16'h0000);
        drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 4'd15);
        step();
        check("r4_cleared", DataA, 16'h0000);
        check("r15_cleared", DataB, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Core general-purpose register file: 2 read ports, 1 write port.
- Registered read outputs DataA/DataB drive the 16-bit operand bus multiplexer inputs A and B directly.
- Write port is fed from the writeback result bus.
- Read data has a fixed 1-cycle latency, so the operand mux sees stable values for a full cycle.

Parameters:
- WIDTH, 16, data width of each register and of all data ports.
- ADDR_BITS, 4, register address width; register count = 2**ADDR_BITS (16).

Ports:
- Clock  input  1  rising-edge clock; all state updates on posedge.
- Reset  input  1  synchronous, active-low reset; sampled on posedge Clock.
- ReadEnable  input  1  1 = update DataA/DataB this edge; 0 = hold them.
- ReadAddrA  input  ADDR_BITS  register index for port A.
- ReadAddrB  input  ADDR_BITS  register index for port B.
- WriteEnable  input  1  1 = write WriteData into WriteAddr this edge.
- WriteAddr  input  ADDR_BITS  destination register index.
- WriteData  input  WIDTH  data to write.
- DataA  output  WIDTH  registered read data, port A (to operand mux InputA).
- DataB  output  WIDTH  registered read data, port B (to operand mux InputB).
- ReadValid  output  1  high the cycle after an accepted read (ReadEnable=1 edge).

Behaviour:
- Reset: Clock and Reset are the single clock and synchronous active-low reset; no asynchronous paths.
- At a posedge with Reset=0:
  - all 2**ADDR_BITS registers <= 0; DataA <= 0; DataB <= 0; ReadValid <= 0.
  - WriteEnable and ReadEnable are ignored that edge.
  - Reset asserted mid-operation discards any in-flight write or read.
- Write: at a posedge with Reset=1 and WriteEnable=1, Reg[WriteAddr] <= WriteData. No register is hardwired; r0 is writable.
- Read: at a posedge with Reset=1 and ReadEnable=1:
  - DataA <= Reg[ReadAddrA] and DataB <= Reg[ReadAddrB], using pre-edge register contents (subject to Optional Feature).
  - ReadValid <= 1.
- Hold: with ReadEnable=0, DataA/DataB hold their previous value and ReadValid <= 0. Writes still occur.
- Latency: address presented before edge N produces data valid after edge N; readable in cycle N+1.
- Both ports may address the same register; each gets an identical value.
- Write landing on a held register does not change DataA/DataB until the next ReadEnable=1 edge.
- Write-after-write to the same address on consecutive edges: last write wins.
- Addresses are full-range; no out-of-range case exists. No X is ever driven after the first reset edge.
- State: storage array plus output registers only. No FSM.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. On an edge with WriteEnable=1, ReadEnable=1 and ReadAddrA==WriteAddr:
  - DataA <= WriteData, i.e. the new value, not the stale one.
  - The same rule applies independently to port B.
  - The storage write still happens.
- Undefined: no forwarding. Same-edge read of the register being written returns the old value; the new value is visible on the next read edge.
- Reset has priority over the bypass in both builds.

Test Plan:
- Reset=0 for 1 edge, then read addr A=3, B=15 -> DataA=0x0000, DataB=0x0000, ReadValid=1 one cycle later.
- Write R5=0xBEEF, next edge read A=5, B=5 -> DataA=DataB=0xBEEF after that edge.
- Same edge: write R7=0x1234 (R7 previously 0x00AA) and read A=7:
  - with REGFILE_BYPASS_EN -> DataA=0x1234.
  - without -> DataA=0x00AA, then 0x1234 on the following read edge.
- Read A=2 (0x1111), then ReadEnable=0 while writing R2=0x2222 -> DataA stays 0x1111 and ReadValid=0. Next ReadEnable=1 edge -> DataA=0x2222.
- Write all 16 registers with value 0x1000+index, then read pairs (0,15), (8,7) -> (0x1000,0x100F), (0x1008,0x1007).
- Load R4=0xFFFF, then assert Reset=0 on the same edge as a write R4=0x5555 and a read A=4 -> DataA=0, R4 reads 0x0000 afterwards.
